// File: rtl/tlb_op_ctrl.sv
// TLB instruction sequencer: runs one TLBP/TLBR/TLBWI at a time against the
// TLB entry array and writes results back to the CP0 TLB registers.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | op_ready high, waiting for op_valid; snapshots CP0 on accept
// WRITE    | TLBWI: array write strobe at snapshot Index, done
// READ_REQ | TLBR: array read strobe at snapshot Index
// READ_WB  | TLBR: returned entry written to EntryHi/EntryLo0/EntryLo1, done
// PROBE    | TLBP: pipelined linear scan; read i while comparing entry i-1
// FIN      | NOP: done with no side effects
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [1:0]       op_type,
  output logic             op_ready,
  output logic             busy,
  output logic             done,
  input  logic [18:0]      VPN2,
  input  logic [7:0]       ASID,
  input  logic [IDX_W-1:0] Index,
  input  logic [25:0]      EntryLo0,
  input  logic [25:0]      EntryLo1,
  output logic             tlb_re,
  output logic [IDX_W-1:0] tlb_raddr,
  input  logic [77:0]      tlb_rdata,
  output logic             tlb_we,
  output logic [IDX_W-1:0] tlb_waddr,
  output logic [77:0]      tlb_wdata,
  output logic [3:0]       wen,
  output logic [31:0]      EntryHi_wdata,
  output logic [31:0]      EntryLo0_wdata,
  output logic [31:0]      EntryLo1_wdata,
  output logic [31:0]      IndexReg_wdata
);

  typedef enum logic [2:0] {IDLE, WRITE, READ_REQ, READ_WB, PROBE, FIN} state_t;

  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(TLBNUM);
  localparam logic [IDX_W:0] ONE  = (IDX_W+1)'(1);

  state_t           state;
  logic [IDX_W:0]   cnt;
  logic [IDX_W:0]   cnt_m1;
  logic [18:0]      vpn2_s;
  logic [7:0]       asid_s;
  logic [IDX_W-1:0] idx_s;

  logic [18:0] e_vpn2;
  logic [7:0]  e_asid;
  logic        e_g;
  logic [19:0] e_pfn0, e_pfn1;
  logic [2:0]  e_c0, e_c1;
  logic        e_d0, e_v0, e_d1, e_v1;
  logic        hit;
  logic        probe_end;

  assign {e_vpn2, e_asid, e_g, e_pfn0, e_c0, e_d0, e_v0, e_pfn1, e_c1, e_d1, e_v1} = tlb_rdata;

  // cnt==0 is the first scan cycle: nothing has been read back yet
  assign hit       = (state == PROBE) && (cnt != '0) && (e_vpn2 == vpn2_s) &&
                     (e_g || (e_asid == asid_s));
  assign probe_end = (state == PROBE) && (hit || (cnt == LAST));
  assign cnt_m1    = cnt - ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      vpn2_s    <= '0;
      asid_s    <= '0;
      idx_s     <= '0;
      op_ready  <= 1'b1;
      busy      <= 1'b0;
      tlb_we    <= 1'b0;
      tlb_waddr <= '0;
      tlb_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            vpn2_s   <= VPN2;
            asid_s   <= ASID;
            idx_s    <= Index;
            cnt      <= '0;
            op_ready <= 1'b0;
            busy     <= 1'b1;
            case (op_type)
              2'b01: state <= PROBE;
              2'b10: state <= READ_REQ;
              2'b11: begin
                state     <= WRITE;
                tlb_we    <= 1'b1;
                tlb_waddr <= Index;
                tlb_wdata <= {VPN2, ASID, EntryLo0[0] & EntryLo1[0],
                              EntryLo0[25:1], EntryLo1[25:1]};
              end
              default: state <= FIN;
            endcase
          end
        end
        READ_REQ: state <= READ_WB;
        PROBE: begin
          if (probe_end) begin
            state    <= IDLE;
            op_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state     <= IDLE;
          op_ready  <= 1'b1;
          busy      <= 1'b0;
          tlb_we    <= 1'b0;
          tlb_waddr <= '0;
          tlb_wdata <= '0;
        end
      endcase
    end
  end

  // Read-data-dependent outputs must be decoded in the cycle the data returns
  always_comb begin
    tlb_re         = 1'b0;
    tlb_raddr      = '0;
    done           = 1'b0;
    wen            = 4'b0000;
    EntryHi_wdata  = '0;
    EntryLo0_wdata = '0;
    EntryLo1_wdata = '0;
    IndexReg_wdata = '0;
    case (state)
      WRITE, FIN: done = 1'b1;
      READ_REQ: begin
        tlb_re    = 1'b1;
        tlb_raddr = idx_s;
      end
      READ_WB: begin
        done           = 1'b1;
        wen            = 4'b1110;
        EntryHi_wdata  = {e_vpn2, 5'b0, e_asid};
        EntryLo0_wdata = {6'b0, e_pfn0, e_c0, e_d0, e_v0, e_g};
        EntryLo1_wdata = {6'b0, e_pfn1, e_c1, e_d1, e_v1, e_g};
      end
      PROBE: begin
        if ((cnt != LAST) && !hit) begin
          tlb_re    = 1'b1;
          tlb_raddr = cnt[IDX_W-1:0];
        end
        if (probe_end) begin
          done           = 1'b1;
          wen            = 4'b0001;
          IndexReg_wdata = hit ? 32'(cnt_m1[IDX_W-1:0]) : 32'h8000_0000;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
- Sequences TLB-management instructions (TLBP, TLBR, TLBWI) between the pipeline, the CP0 TLB-facing registers and the TLB entry array.
- Takes one op at a time from the pipeline and holds `busy` while it runs.
- Drives the array's synchronous read port and its write port.
- Writes results back through CP0's `wen`/`*_wdata` port.
- TLBP is a multi-cycle linear scan of the array.

Parameters:
TLBNUM, 16, number of TLB entries (power of two, 2..32)
IDX_W, 4, log2(TLBNUM)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
op_valid  in  1  op request from pipeline
op_type  in  2  01=TLBP, 10=TLBR, 11=TLBWI, 00=NOP
op_ready  out  1  high only in IDLE; op accepted when op_valid & op_ready
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle pulse in the op's final cycle
VPN2  in  19  CP0 EntryHi VPN2
ASID  in  8  CP0 EntryHi ASID
Index  in  IDX_W  CP0 Index low bits
EntryLo0  in  26  CP0 EntryLo0[25:0] (PFN,C,D,V,G)
EntryLo1  in  26  CP0 EntryLo1[25:0]
tlb_re  out  1  array read strobe
tlb_raddr  out  IDX_W  read index
tlb_rdata  in  78  entry, valid the cycle after tlb_re: {VPN2[77:59], ASID[58:51], G[50], PFN0[49:30], C0[29:27], D0[26], V0[25], PFN1[24:5], C1[4:2], D1[1], V1[0]}
tlb_we  out  1  array write strobe
tlb_waddr  out  IDX_W  write index
tlb_wdata  out  78  entry, same format
wen  out  4  CP0 write enables: [3]EntryHi [2]EntryLo0 [1]EntryLo1 [0]IndexReg
EntryHi_wdata  out  32  CP0 write data
EntryLo0_wdata  out  32  CP0 write data
EntryLo1_wdata  out  32  CP0 write data
IndexReg_wdata  out  32  CP0 write data

Behaviour:
- States: IDLE, WRITE, READ_REQ, READ_WB, PROBE, FIN.
- Reset:
  - state=IDLE, scan counter=0, snapshot registers=0.
  - All strobes and wdata outputs are 0, op_ready=1, busy=0, done=0.
  - Reset mid-op aborts the op; no further array or CP0 writes occur.
- Accept (IDLE, cycle T):
  - Snapshot VPN2, ASID, Index, EntryLo0, EntryLo1 into internal registers.
  - All later actions use the snapshot only; CP0 changes during the op are ignored.
  - op_valid while busy is ignored; requester must hold the request until accepted.
- NOP (op_type 00): goes to FIN; done at T+1; no side effects.
- TLBWI: T+1 in WRITE.
  - tlb_we=1, tlb_waddr=Index.
  - tlb_wdata packed from the snapshot, with G = EntryLo0.G & EntryLo1.G.
  - done=1; next state IDLE.
- TLBR:
  - T+1 READ_REQ: tlb_re=1, tlb_raddr=Index.
  - T+2 READ_WB: wen=4'b1110; done=1; next state IDLE.
  - EntryHi_wdata={VPN2,5'b0,ASID}.
  - EntryLo0_wdata={6'b0,PFN0,C0,D0,V0,G}.
  - EntryLo1_wdata={6'b0,PFN1,C1,D1,V1,G}.
  - Index register is not written.
- TLBP (PROBE), pipelined scan with a counter i starting at 0:
  - Each cycle with i<TLBNUM: tlb_re=1, tlb_raddr=i, then i increments.
  - Each cycle after the first: compare the returned entry k=i-1.
  - Match = (entry.VPN2==VPN2) && (entry.G || entry.ASID==ASID). V bits are ignored.
  - On the first match (lowest index wins): wen=4'b0001, IndexReg_wdata={1'b0,(31-IDX_W)'b0,k}, done=1, next state IDLE. Done lands at T+k+2.
  - If entry TLBNUM-1 is compared without a match: wen=4'b0001, IndexReg_wdata=32'h8000_0000 (P bit), done=1. Done lands at T+TLBNUM+1.
  - Reads issued after the match cycle are discarded; tlb_re=0 in the done cycle.
- Exclusivity: tlb_we and any wen bit are never asserted in the same cycle; at most one op is in flight.
- Default values: outputs not listed for a state are 0 in that state.
- Throughput: op_ready returns in the cycle after done; back-to-back ops have a one-cycle IDLE gap.

Test Plan:
- TLBWI: Index=5, VPN2=19'h12345, ASID=8'h3A, G0=G1=1 -> one cycle after accept: tlb_we=1, waddr=5, wdata[50]=1, done=1; no wen.
- TLBR: array[7]={VPN2=19'h00ABC, ASID=8'h11, G=0, PFN0=20'h00100, C0=3, D0=1, V0=1, ...}, Index=7 -> re at T+1 with raddr=7; at T+2 wen=4'b1110, EntryHi_wdata=32'h01578011, EntryLo0_wdata=32'h0000401E.
- TLBP hit: entry 9 has VPN2 match, ASID mismatch, G=1; entry 12 also matches -> done at T+11, IndexReg_wdata=32'h0000_0009.
- TLBP miss, TLBNUM=16: no entry matches -> done at T+17, IndexReg_wdata=32'h8000_0000, 16 read strobes issued.
- Robustness: CP0 VPN2 changed during a probe, op_valid held while busy, and rst asserted at scan i=4 -> snapshot is used and the held request is accepted only after done; after reset no wen, tlb_we or done, and op_ready=1.
